// File: rtl/instr_encoder_pkg.sv
// rtl/instr_encoder_pkg.sv - shared formats, opcodes, funct3 codes and immediate range helper
package instr_encoder_pkg;

  typedef enum logic [3:0] {
    FMT_R, FMT_I, FMT_F, FMT_LOAD, FMT_STORE, FMT_FLOAD,
    FMT_FSTORE, FMT_LUI, FMT_JAL, FMT_BEQZ, FMT_SYNC, FMT_EXIT
  } instr_fmt_t;

  localparam logic [2:0] OPCODE_R  = 3'b000;
  localparam logic [2:0] OPCODE_I  = 3'b001;
  localparam logic [2:0] OPCODE_F  = 3'b010;
  localparam logic [2:0] OPCODE_M  = 3'b011;
  localparam logic [2:0] OPCODE_UP = 3'b100;
  localparam logic [2:0] OPCODE_J  = 3'b101;

  localparam logic [2:0] M_LOAD   = 3'b000;
  localparam logic [2:0] M_STORE  = 3'b001;
  localparam logic [2:0] M_FLOAD  = 3'b010;
  localparam logic [2:0] M_FSTORE = 3'b011;

  localparam logic [2:0] J_JAL  = 3'b000;
  localparam logic [2:0] J_BEQZ = 3'b001;
  localparam logic [2:0] J_SYNC = 3'b110;
  localparam logic [2:0] J_EXIT = 3'b111;

  // True when imm survives truncation to a bits-wide two's complement field.
  function automatic logic fits_signed(input logic [31:0] imm, input int unsigned bits);
    logic [31:0] hi;
    hi = $unsigned($signed(imm) >>> (bits - 1));
    return (hi == 32'h0) || (hi == 32'hFFFF_FFFF);
  endfunction

endpackage

// File: rtl/instr_encoder_pack.sv
// rtl/instr_encoder_pack.sv - instr_pack: combinational bit packing of one instruction word
module instr_pack
  import instr_encoder_pkg::*;
(
  input  instr_fmt_t  fmt,
  input  logic [3:0]  funct4,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  input  logic        scalar,
  output logic [31:0] instr
);

  always_comb begin
    instr = '0;
    case (fmt)
      FMT_R, FMT_F: begin
        instr[31:29] = (fmt == FMT_R) ? OPCODE_R : OPCODE_F;
        instr[28]    = scalar;
        instr[18:14] = rs2;
        instr[13:10] = funct4;
        instr[9:5]   = rs1;
        instr[4:0]   = rd;
      end
      FMT_I: begin
        instr[31:29] = OPCODE_I;
        instr[28]    = scalar;
        instr[27:14] = imm[13:0];
        instr[13:10] = funct4;
        instr[9:5]   = rs1;
        instr[4:0]   = rd;
      end
      FMT_LOAD, FMT_FLOAD: begin
        instr[31:29] = OPCODE_M;
        instr[28:14] = imm[14:0];
        instr[13]    = scalar;
        instr[12:10] = (fmt == FMT_LOAD) ? M_LOAD : M_FLOAD;
        instr[9:5]   = rs1;
        instr[4:0]   = rd;
      end
      FMT_STORE, FMT_FSTORE: begin
        instr[31:29] = OPCODE_M;
        instr[28:19] = imm[14:5];
        instr[18:14] = rs2;
        instr[13]    = scalar;
        instr[12:10] = (fmt == FMT_STORE) ? M_STORE : M_FSTORE;
        instr[9:5]   = rs1;
        instr[4:0]   = imm[4:0];
      end
      FMT_LUI: begin
        instr[31:29] = OPCODE_UP;
        instr[28:9]  = imm[31:12];
        instr[5]     = scalar;
        instr[4:0]   = rd;
      end
      FMT_JAL: begin
        instr[31:29] = OPCODE_J;
        instr[28:13] = imm[25:10];
        instr[12:10] = J_JAL;
        instr[9:0]   = imm[9:0];
      end
      FMT_BEQZ: begin
        instr[31:29] = OPCODE_J;
        instr[28:19] = imm[15:6];
        instr[18:14] = rs2;
        instr[13]    = imm[5];
        instr[12:10] = J_BEQZ;
        instr[9:5]   = rs1;
        instr[4:0]   = imm[4:0];
      end
      FMT_SYNC: instr = {OPCODE_J, 16'h0, J_SYNC, 10'h0};
      FMT_EXIT: instr = {OPCODE_J, 16'h0, J_EXIT, 10'h0};
      default:  instr = '0;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - encoder top: 2-entry output FIFO, address counter, legality checks
// Optional macro ENCODER_CHECK_EN enables field checks, err_pulse and err_count.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int                ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  instr_fmt_t        in_fmt,
  input  logic [3:0]        in_funct4,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  input  logic              in_scalar,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err_pulse,
  output logic [7:0]        err_count
);

  logic [31:0]       packed_instr;
  logic              legal;
  logic              accept, push, pop;
  logic [31:0]       mem_instr [2];
  logic [ADDR_W-1:0] mem_addr  [2];
  logic              wr_ptr, rd_ptr;
  logic [1:0]        count;
  logic [ADDR_W-1:0] addr;

  instr_pack u_pack (
    .fmt    (in_fmt),
    .funct4 (in_funct4),
    .rd     (in_rd),
    .rs1    (in_rs1),
    .rs2    (in_rs2),
    .imm    (in_imm),
    .scalar (in_scalar),
    .instr  (packed_instr)
  );

  // in_ready depends only on the registered count, never on out_ready.
  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign out_instr = mem_instr[rd_ptr];
  assign out_addr  = mem_addr[rd_ptr];

  assign accept = in_valid && in_ready && !flush;
  assign push   = accept && legal;
  assign pop    = out_valid && out_ready && !flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      addr   <= BASE_ADDR;
      for (int i = 0; i < 2; i++) begin
        mem_instr[i] <= '0;
        mem_addr[i]  <= BASE_ADDR;
      end
    end else if (flush) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      addr   <= BASE_ADDR;
    end else begin
      if (push) begin
        mem_instr[wr_ptr] <= packed_instr;
        mem_addr[wr_ptr]  <= addr;
        wr_ptr            <= ~wr_ptr;
        addr              <= addr + ADDR_W'(1);
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

`ifdef ENCODER_CHECK_EN
  always_comb begin
    legal = 1'b1;
    case (in_fmt)
      FMT_R:   legal = (in_funct4 <= 4'd9);
      FMT_F:   legal = (in_funct4 <= 4'd10);
      FMT_I:   legal = fits_signed(in_imm, 14) &&
                       (in_funct4 inside {4'd0, 4'd2, 4'd3, 4'd10});
      FMT_LOAD, FMT_STORE, FMT_FLOAD, FMT_FSTORE:
               legal = fits_signed(in_imm, 15);
      FMT_BEQZ: legal = fits_signed(in_imm, 16);
      FMT_JAL:  legal = fits_signed(in_imm, 26);
      FMT_LUI:  legal = (in_imm[11:0] == 12'h0);
      default:  legal = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_pulse <= 1'b0;
      err_count <= 8'd0;
    end else begin
      err_pulse <= accept && !legal;
      if (accept && !legal && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end
`else
  assign legal     = 1'b1;
  assign err_pulse = 1'b0;
  assign err_count = 8'd0;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - directed table-driven bench for instr_encoder
module tb_instr_encoder;
  import instr_encoder_pkg::*;

  logic        clk, reset, flush, in_valid, in_ready, out_valid, out_ready;
  instr_fmt_t  in_fmt;
  logic [3:0]  in_funct4;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [31:0] in_imm, out_instr;
  logic        in_scalar, err_pulse;
  logic [7:0]  out_addr, err_count;
  logic        w_in_ready, w_out_valid, w_err_pulse;
  logic [31:0] w_out_instr;
  logic [1:0]  w_out_addr;
  logic [7:0]  w_err_count;

  int checks = 0;
  int errors = 0;

  instr_encoder dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_funct4(in_funct4), .in_rd(in_rd), .in_rs1(in_rs1),
    .in_rs2(in_rs2), .in_imm(in_imm), .in_scalar(in_scalar), .out_valid(out_valid),
    .out_ready(out_ready), .out_instr(out_instr), .out_addr(out_addr),
    .err_pulse(err_pulse), .err_count(err_count)
  );

  instr_encoder #(.ADDR_W(2)) dut_w (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(w_in_ready),
    .in_fmt(in_fmt), .in_funct4(in_funct4), .in_rd(in_rd), .in_rs1(in_rs1),
    .in_rs2(in_rs2), .in_imm(in_imm), .in_scalar(in_scalar), .out_valid(w_out_valid),
    .out_ready(out_ready), .out_instr(w_out_instr), .out_addr(w_out_addr),
    .err_pulse(w_err_pulse), .err_count(w_err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    instr_fmt_t  fmt;
    logic [3:0]  f4;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic        sc;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, got, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    in_fmt = v.fmt; in_funct4 = v.f4; in_rd = v.rd; in_rs1 = v.rs1;
    in_rs2 = v.rs2; in_imm = v.imm; in_scalar = v.sc; in_valid = 1'b1;
  endtask

  function automatic vec_t addi(input logic [4:0] rd);
    vec_t v;
    v = '{FMT_I, 4'd0, rd, 5'd1, 5'd0, 32'hFFFF_FFFF, 1'b1, 32'h3FFF_C020 | {27'd0, rd}};
    return v;
  endfunction

  task automatic tick;
    @(posedge clk); #1;
  endtask

  initial begin
    vec_t v;
    int   got;
    logic pop_now, acc_now;

    vecs[0]  = '{FMT_I,      4'd0,  5'd3,  5'd1,  5'd0,  32'hFFFF_FFFF, 1'b1, 32'h3FFF_C023};
    vecs[1]  = '{FMT_R,      4'd5,  5'd7,  5'd2,  5'd9,  32'hDEAD_BEEF, 1'b0, 32'h0002_5447};
    vecs[2]  = '{FMT_F,      4'd10, 5'd31, 5'd31, 5'd31, 32'h0,         1'b1, 32'h5007_EBFF};
    vecs[3]  = '{FMT_LOAD,   4'd0,  5'd4,  5'd5,  5'd0,  32'h0000_1234, 1'b0, 32'h648D_00A4};
    vecs[4]  = '{FMT_FLOAD,  4'd0,  5'd1,  5'd2,  5'd0,  32'hFFFF_FFFE, 1'b1, 32'h7FFF_A841};
    vecs[5]  = '{FMT_STORE,  4'd0,  5'd0,  5'd3,  5'd6,  32'h0000_02A5, 1'b0, 32'h60A9_8465};
    vecs[6]  = '{FMT_FSTORE, 4'd0,  5'd0,  5'd0,  5'd1,  32'hFFFF_FFFF, 1'b1, 32'h7FF8_6C1F};
    vecs[7]  = '{FMT_LUI,    4'd0,  5'd9,  5'd31, 5'd0,  32'hABCD_E000, 1'b1, 32'h9579_BC29};
    vecs[8]  = '{FMT_JAL,    4'd0,  5'd0,  5'd0,  5'd0,  32'h0012_3456, 1'b0, 32'hA091_A056};
    vecs[9]  = '{FMT_BEQZ,   4'd0,  5'd0,  5'd2,  5'd0,  32'hFFFF_8021, 1'b0, 32'hB000_2441};
    vecs[10] = '{FMT_SYNC,   4'd7,  5'd5,  5'd6,  5'd7,  32'hFFFF_FFFF, 1'b1, 32'hA000_1800};
    vecs[11] = '{FMT_EXIT,   4'd7,  5'd5,  5'd6,  5'd7,  32'hFFFF_FFFF, 1'b1, 32'hA000_1C00};

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_fmt = FMT_R; in_funct4 = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    in_imm = '0; in_scalar = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    check("rst_out_valid", {31'd0, out_valid}, 0);
    check("rst_out_instr", out_instr, 0);
    check("rst_out_addr", {24'd0, out_addr}, 0);
    check("rst_in_ready", {31'd0, in_ready}, 1);
    check("rst_err", {23'd0, err_pulse, err_count}, 0);
    check("rst_w", {w_in_ready, w_out_valid, w_err_pulse, w_err_count, w_out_instr[20:0]}, 32'h8000_0000);

    // Table: one word at a time with the consumer always ready.
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i]);
      tick();
      in_valid = 1'b0;
      check($sformatf("vec%0d_valid", i), {31'd0, out_valid}, 1);
      check($sformatf("vec%0d_instr", i), out_instr, vecs[i].exp);
      check($sformatf("vec%0d_addr", i), {24'd0, out_addr}, i);
      tick();
      check($sformatf("vec%0d_drained", i), {31'd0, out_valid}, 0);
    end

    // Backpressure: three back-to-back inputs against a stalled consumer.
    out_ready = 1'b0;
    drive(addi(5'd1));
    tick();
    check("bp_ready_after1", {31'd0, in_ready}, 1);
    in_rd = 5'd2;
    tick();
    check("bp_ready_after2", {31'd0, in_ready}, 0);
    check("bp_head_addr", {24'd0, out_addr}, 12);
    in_rd = 5'd3;
    tick();
    check("bp_stall_ready", {31'd0, in_ready}, 0);
    check("bp_stall_addr", {24'd0, out_addr}, 12);
    out_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 20 && got < 3; c++) begin
      pop_now = out_valid && out_ready;
      acc_now = in_valid && in_ready;
      if (pop_now) begin
        check($sformatf("bp_addr%0d", got), {24'd0, out_addr}, 12 + got);
        check($sformatf("bp_rd%0d", got), {27'd0, out_instr[4:0]}, got + 1);
        got++;
      end
      tick();
      if (acc_now) in_valid = 1'b0;
    end
    check("bp_count", got, 3);
    check("bp_empty", {31'd0, out_valid}, 0);

    // Reset mid-transfer discards queued words.
    out_ready = 1'b0;
    drive(addi(5'd4)); tick();
    in_rd = 5'd5; tick();
    in_valid = 1'b0;
    reset = 1'b1; tick(); reset = 1'b0;
    check("midrst_valid", {31'd0, out_valid}, 0);
    check("midrst_instr", out_instr, 0);
    check("midrst_addr", {24'd0, out_addr}, 0);
    check("midrst_ready", {31'd0, in_ready}, 1);

    // Flush with two queued and with one queued plus a real concurrent accept.
    drive(addi(5'd6)); tick();
    in_rd = 5'd7; tick();
    check("fl_full", {31'd0, in_ready}, 0);
    in_rd = 5'd8; out_ready = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0; out_ready = 1'b0;
    check("fl2_valid", {31'd0, out_valid}, 0);
    check("fl2_ready", {31'd0, in_ready}, 1);
    in_rd = 5'd9; tick();
    in_rd = 5'd10; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("fl1_valid", {31'd0, out_valid}, 0);

    // Post-flush words start at BASE_ADDR; the 2-bit instance wraps.
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      drive(addi(5'(k + 11)));
      tick();
      in_valid = 1'b0;
      check($sformatf("wrap%0d_addr", k), {24'd0, out_addr}, k);
      check($sformatf("wrap%0d_waddr", k), {30'd0, w_out_addr}, k % 4);
      check($sformatf("wrap%0d_winstr", k), {w_out_valid, w_out_instr[30:0]},
            {1'b1, 31'h3FFF_C020} | (k + 11));
      tick();
    end

    // Out-of-range I immediate: dropped when checks are built in, truncated otherwise.
    v = '{FMT_I, 4'd0, 5'd0, 5'd0, 5'd0, 32'd8192, 1'b0, 32'h2800_0000};
    drive(v);
    tick();
    in_valid = 1'b0;
`ifdef ENCODER_CHECK_EN
    check("chk_pulse", {31'd0, err_pulse}, 1);
    check("chk_count", {24'd0, err_count}, 1);
    check("chk_dropped", {31'd0, out_valid}, 0);
    tick();
    check("chk_pulse_end", {31'd0, err_pulse}, 0);
    drive(addi(5'd20));
    tick();
    in_valid = 1'b0;
    check("chk_next_addr", {24'd0, out_addr}, 5);
    check("chk_next_valid", {31'd0, out_valid}, 1);
`else
    check("trunc_valid", {31'd0, out_valid}, 1);
    check("trunc_instr", out_instr, v.exp);
    check("trunc_addr", {24'd0, out_addr}, 5);
    check("trunc_err", {23'd0, err_pulse, err_count}, 0);
`endif
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
